// File: rtl/gshare_bht_pkg.sv
// Shared definitions for the gshare branch history table: counter encodings
// and the index hash, so the resolve stage can rebuild the same index.
package gshare_bht_pkg;

   typedef enum logic [1:0] {
      CNT_SNT = 2'd0,
      CNT_WNT = 2'd1,
      CNT_WT  = 2'd2,
      CNT_ST  = 2'd3
   } bht_cnt_e;

   localparam int HASH_W = 32;

   // Word-aligned PC bits XOR zero-extended history, masked to idx_w bits.
   function automatic logic [HASH_W-1:0] bht_hash(input logic [HASH_W-1:0] pc,
                                                  input logic [HASH_W-1:0] hist,
                                                  input int                idx_w);
      logic [HASH_W-1:0] mask;
      mask = (HASH_W'(1) << idx_w) - HASH_W'(1);
      return ((pc >> 2) ^ hist) & mask;
   endfunction

endpackage

// File: rtl/gshare_bht_sat_step.sv
// Combinational saturating step for one table counter; also exposes the
// prediction bit of the current (pre-update) value.
module bht_sat_step #(
   parameter int CNT_W = 2
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             taken,
   output logic [CNT_W-1:0] cnt_next,
   output logic             pred
);

   always_comb begin
      cnt_next = cnt;
      if (taken && (cnt != {CNT_W{1'b1}})) begin
         cnt_next = cnt + CNT_W'(1);
      end else if (!taken && (cnt != '0)) begin
         cnt_next = cnt - CNT_W'(1);
      end
      pred = cnt[CNT_W-1];
   end

endmodule

// File: rtl/gshare_bht.sv
// gshare branch history table: registered lookup, counter training with
// global history shift on resolve, and a saturating misprediction counter.
module gshare_bht
   import gshare_bht_pkg::*;
#(
   parameter int PC_W   = 16,
   parameter int IDX_W  = 4,
   parameter int HIST_W = 4,
   parameter int CNT_W  = 2,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              lookup_valid,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [IDX_W-1:0]  pred_idx,
   input  logic              update_valid,
   input  logic [IDX_W-1:0]  update_idx,
   input  logic              update_taken,
   output logic [HIST_W-1:0] hist,
   output logic [STAT_W-1:0] mispred_count
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [CNT_W-1:0]  tbl [ENTRIES];
   logic [IDX_W-1:0]  lookup_idx;
   logic [CNT_W-1:0]  upd_cnt_next;
   logic              upd_pred;
   logic              mispredict;
   logic [HIST_W-1:0] hist_next;

   assign lookup_idx = IDX_W'(bht_hash(HASH_W'(lookup_pc), HASH_W'(hist), IDX_W));
   assign mispredict = upd_pred != update_taken;
   // Truncating the concatenation drops the oldest bit and also covers HIST_W=1.
   assign hist_next  = HIST_W'({hist, update_taken});

   bht_sat_step #(.CNT_W(CNT_W)) u_step (
      .cnt      (tbl[update_idx]),
      .taken    (update_taken),
      .cnt_next (upd_cnt_next),
      .pred     (upd_pred)
   );

   // Lookup reads the table and hist before this edge's update lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl[i] <= CNT_W'(CNT_SNT);
         end
         hist          <= '0;
         mispred_count <= '0;
         pred_valid    <= 1'b0;
         pred_taken    <= 1'b0;
         pred_idx      <= '0;
      end else begin
         pred_valid <= lookup_valid;
         if (lookup_valid) begin
            pred_idx   <= lookup_idx;
            pred_taken <= tbl[lookup_idx][CNT_W-1];
         end
         if (update_valid) begin
            tbl[update_idx] <= upd_cnt_next;
            hist            <= hist_next;
            if (mispredict && (mispred_count != {STAT_W{1'b1}})) begin
               mispred_count <= mispred_count + STAT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_gshare_bht.sv
// Directed bench for gshare_bht: predictions go through a scoreboard queue
// checked by a monitor; history and statistics are checked inline.
module tb_gshare_bht;

   logic        clk;
   logic        reset;
   logic        lookup_valid;
   logic [15:0] lookup_pc;
   logic        update_valid;
   logic [3:0]  update_idx;
   logic        update_taken;

   logic        pred_valid,   s_pred_valid;
   logic        pred_taken,   s_pred_taken;
   logic [3:0]  pred_idx,     s_pred_idx;
   logic [3:0]  hist,         s_hist;
   logic [15:0] mispred_count;
   logic [1:0]  s_mispred_count;

   int n_checks = 0;
   int n_pass   = 0;
   logic [4:0] exp_q [$];

   gshare_bht dut (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_idx(pred_idx),
      .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken),
      .hist(hist), .mispred_count(mispred_count)
   );

   gshare_bht #(.STAT_W(2)) dut_s (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
      .pred_valid(s_pred_valid), .pred_taken(s_pred_taken), .pred_idx(s_pred_idx),
      .update_valid(update_valid), .update_idx(update_idx), .update_taken(update_taken),
      .hist(s_hist), .mispred_count(s_mispred_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every presented prediction must match the oldest expectation.
   always begin
      @(posedge clk);
      #2;
      if (pred_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pred", 32'(pred_idx), 32'hFFFF_FFFF);
         end else begin
            logic [4:0] e;
            e = exp_q.pop_front();
            check("pred_idx", 32'(pred_idx), 32'(e[4:1]));
            check("pred_taken", 32'(pred_taken), 32'(e[0]));
         end
      end
   end

   task automatic cyc(input logic rst, input logic lv, input logic [15:0] pc,
                      input logic uv, input logic [3:0] uidx, input logic ut);
      reset        = rst;
      lookup_valid = lv;
      lookup_pc    = pc;
      update_valid = uv;
      update_idx   = uidx;
      update_taken = ut;
      @(posedge clk);
      #1;
      reset        = 1'b0;
      lookup_valid = 1'b0;
      update_valid = 1'b0;
   endtask

   task automatic lookup(input logic [15:0] pc, input logic [3:0] eidx, input logic et);
      exp_q.push_back({eidx, et});
      cyc(1'b0, 1'b1, pc, 1'b0, 4'd0, 1'b0);
   endtask

   task automatic upd(input logic [3:0] uidx, input logic ut);
      cyc(1'b0, 1'b0, 16'h0, 1'b1, uidx, ut);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
      update_valid = 1'b0; update_idx = '0; update_taken = 1'b0;
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
      cyc(1'b1, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
      check("rst_pred_valid", 32'(pred_valid), 0);
      check("rst_pred_idx", 32'(pred_idx), 0);
      check("rst_pred_taken", 32'(pred_taken), 0);
      check("rst_hist", 32'(hist), 0);
      check("rst_mispred", 32'(mispred_count), 0);

      lookup(16'h0010, 4'd4, 1'b0);
      check("hist_after_lookup", 32'(hist), 0);
      upd(4'd4, 1'b1);
      upd(4'd4, 1'b1);
      check("hist_two_taken", 32'(hist), 32'h3);
      check("mispred_two", 32'(mispred_count), 2);
      lookup(16'h0010, 4'd7, 1'b0);
      lookup(16'h001C, 4'd4, 1'b1);

      // Taken saturation at idx 0, then walk back down without wrap.
      for (int i = 0; i < 5; i++) upd(4'd0, 1'b1);
      check("hist_all_taken", 32'(hist), 32'hF);
      check("mispred_sat_taken", 32'(mispred_count), 4);
      check("stat2_saturated", 32'(s_mispred_count), 3);
      lookup(16'h003C, 4'd0, 1'b1);
      upd(4'd0, 1'b0);
      lookup(16'h0038, 4'd0, 1'b1);
      upd(4'd0, 1'b0);
      lookup(16'h0030, 4'd0, 1'b0);
      check("mispred_walk_down", 32'(mispred_count), 6);

      for (int i = 0; i < 4; i++) upd(4'd1, 1'b0);
      check("hist_all_nt", 32'(hist), 0);
      check("mispred_nt_floor", 32'(mispred_count), 6);
      lookup(16'h0004, 4'd1, 1'b0);
      upd(4'd1, 1'b1);
      check("mispred_from_floor", 32'(mispred_count), 7);
      lookup(16'h0000, 4'd1, 1'b0);

      // Same-cycle lookup and update to idx 1 (counter 1, taken).
      exp_q.push_back({4'd1, 1'b0});
      cyc(1'b0, 1'b1, 16'h0000, 1'b1, 4'd1, 1'b1);
      check("hist_same_cycle", 32'(hist), 32'h3);
      lookup(16'h0008, 4'd1, 1'b1);
      check("mispred_same_cycle", 32'(mispred_count), 8);

      cyc(1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
      check("idle_pred_valid", 32'(pred_valid), 0);
      check("idle_hold_idx", 32'(pred_idx), 1);
      check("idle_hold_taken", 32'(pred_taken), 1);

      // Reset overrides a coincident lookup and update.
      cyc(1'b1, 1'b1, 16'h0008, 1'b1, 4'd1, 1'b1);
      check("rst_mid_pred_valid", 32'(pred_valid), 0);
      check("rst_mid_hist", 32'(hist), 0);
      check("rst_mid_mispred", 32'(mispred_count), 0);
      check("rst_mid_stat2", 32'(s_mispred_count), 0);
      check("rst_mid_pred_idx", 32'(pred_idx), 0);
      for (int i = 0; i < 16; i++) lookup(16'(i * 4), 4'(i), 1'b0);

      // Statistics saturation with a 2-bit counter.
      for (int i = 8; i < 13; i++) upd(4'(i), 1'b1);
      check("stat2_five_mispred", 32'(s_mispred_count), 3);
      check("stat16_five_mispred", 32'(mispred_count), 5);
      upd(4'd13, 1'b1);
      check("stat2_held", 32'(s_mispred_count), 3);
      check("stat16_six", 32'(mispred_count), 6);

      cyc(1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
      cyc(1'b0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0);
      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
